// File: rtl/soc_mmio_pkg.sv
// Shared MMIO definitions for the timer block and the CLINT.
// Holds register offsets, CTRL bit indices, widths, a register-select enum
// and the byte-lane merge used for wmask writes.
package soc_mmio_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STRB_W   = XLEN / 8;
  localparam int unsigned MTIME_W  = 64;
  localparam int unsigned DIV_W    = 16;

  localparam int unsigned CTRL_OFS    = 0;
  localparam int unsigned LOAD_LO_OFS = 4;
  localparam int unsigned LOAD_HI_OFS = 8;

  localparam int unsigned EN_BIT  = 0;
  localparam int unsigned CLR_BIT = 1;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_CTRL = 2'd1,
    REG_LO   = 2'd2,
    REG_HI   = 2'd3
  } reg_sel_e;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0]   old_v,
                                                 input logic [XLEN-1:0]   new_v,
                                                 input logic [STRB_W-1:0] mask);
    logic [XLEN-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtime_prescaler.sv
// Prescaler for the machine timer: emits one increment per eff_div enabled cycles.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   div_i        - period in clk cycles (0 behaves as 1)
//   enable_i     - count enable; when low the phase is held at 0
//   restart_i    - counter clear/load this edge: drop any due tick, restart phase
//   tick_o       - registered pulse, coincident with the counter update
//   inc_c        - combinational increment decision for the counter this edge
module mtime_prescaler
  import soc_mmio_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div_i,
  input  logic             enable_i,
  input  logic             restart_i,
  output logic             tick_o,
  output logic             inc_c
);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] last_c;
  logic             tick_d;

  // ">=" lets a lowered div take effect without wrapping the full 16-bit range.
  always_comb begin
    last_c  = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    inc_c   = enable_i && !restart_i && (presc_q >= last_c);
    tick_d  = inc_c;
    presc_d = presc_q + DIV_W'(1);
    if (restart_i || !enable_i || inc_c) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q <= '0;
      tick_o  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_o  <= tick_d;
    end
  end

endmodule

// File: rtl/mtime_counter.sv
// Free-running 64-bit mtime source for the CLINT, with prescaler and a
// 3-word MMIO window (CTRL, LOAD_LO, LOAD_HI) for start/stop/clear/set.
// Ports:
//   clk, resetn    - clock, synchronous active-low reset
//   valid, addr    - bus request and byte address
//   wmask, wdata   - byte strobes (0 = read) and write data
//   div            - prescaler period in clk cycles (0 behaves as 1)
//   rdata          - read data, combinational from addr (0 on miss)
//   is_valid       - request hits the window
//   ready          - is_valid delayed one cycle
//   tick           - one-cycle pulse per mtime increment
//   timer_counter  - current mtime
module mtime_counter
  import soc_mmio_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h1100_C000,
  parameter logic            EN_RESET  = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [XLEN-1:0]    addr,
  input  logic [STRB_W-1:0]  wmask,
  input  logic [XLEN-1:0]    wdata,
  input  logic [DIV_W-1:0]   div,
  output logic [XLEN-1:0]    rdata,
  output logic               is_valid,
  output logic               ready,
  output logic               tick,
  output logic [MTIME_W-1:0] timer_counter
);

  reg_sel_e           sel_c;
  logic               ctrl_we_c, clr_c, commit_c, inc_c;
  logic               en_q, en_d;
  logic [XLEN-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [MTIME_W-1:0] cnt_q, cnt_d;
  logic               ready_q;

  // Address decode; the select is REG_NONE whenever valid is low.
  always_comb begin
    sel_c = REG_NONE;
    if (valid) begin
      if      (addr == BASE_ADDR + XLEN'(CTRL_OFS))    sel_c = REG_CTRL;
      else if (addr == BASE_ADDR + XLEN'(LOAD_LO_OFS)) sel_c = REG_LO;
      else if (addr == BASE_ADDR + XLEN'(LOAD_HI_OFS)) sel_c = REG_HI;
    end
  end

  assign is_valid = (sel_c != REG_NONE);

  // Register writes, commit/clear decisions and next counter value.
  always_comb begin
    ctrl_we_c = (sel_c == REG_CTRL) && wmask[0];
    en_d      = ctrl_we_c ? wdata[EN_BIT] : en_q;
    clr_c     = ctrl_we_c && wdata[CLR_BIT];
    lo_d      = lo_q;
    hi_d      = hi_q;
    commit_c  = 1'b0;
    if ((sel_c == REG_LO) && (wmask != '0)) lo_d = byte_merge(lo_q, wdata, wmask);
    if ((sel_c == REG_HI) && (wmask != '0)) begin
      hi_d     = byte_merge(hi_q, wdata, wmask);
      commit_c = 1'b1;
    end
    cnt_d = cnt_q;
    if (clr_c)         cnt_d = '0;
    else if (commit_c) cnt_d = {hi_d, lo_q};
    else if (inc_c)    cnt_d = cnt_q + MTIME_W'(1);
  end

  // Readback; clear is write-only and reads 0.
  always_comb begin
    rdata = '0;
    case (sel_c)
      REG_CTRL: rdata[EN_BIT] = en_q;
      REG_LO:   rdata = lo_q;
      REG_HI:   rdata = hi_q;
      default:  rdata = '0;
    endcase
  end

  // Enable must be high both before and after this edge, so a write that
  // disables drops a due tick and a re-enable starts a full period.
  mtime_prescaler u_presc (
    .clk       (clk),
    .resetn    (resetn),
    .div_i     (div),
    .enable_i  (en_q && en_d),
    .restart_i (clr_c || commit_c),
    .tick_o    (tick),
    .inc_c     (inc_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q    <= EN_RESET;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      ready_q <= is_valid;
    end
  end

  assign ready         = ready_q;
  assign timer_counter = cnt_q;

endmodule

// File: tb/tb_mtime_counter.sv
module tb_mtime_counter;

  localparam logic [31:0] BASE  = 32'h1100_C000;
  localparam logic [31:0] A_CTL = BASE;
  localparam logic [31:0] A_LO  = BASE + 32'd4;
  localparam logic [31:0] A_HI  = BASE + 32'd8;
  localparam logic [31:0] A_BAD = BASE + 32'd12;

  localparam int K_CNT = 0;
  localparam int K_TICK = 1;
  localparam int K_ISV = 2;
  localparam int K_RDY = 3;
  localparam int K_RD = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic [15:0] div = 16'd4;
  logic [31:0] rdata;
  logic        is_valid, ready, tick;
  logic [63:0] timer_counter;

  mtime_counter dut (
    .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wmask(wmask),
    .wdata(wdata), .div(div), .rdata(rdata), .is_valid(is_valid),
    .ready(ready), .tick(tick), .timer_counter(timer_counter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(int k);
    case (k)
      K_CNT:   return timer_counter;
      K_TICK:  return 64'(tick);
      K_ISV:   return 64'(is_valid);
      K_RDY:   return 64'(ready);
      default: return 64'(rdata);
    endcase
  endfunction

  task automatic expect_at(int c, int k, logic [63:0] v, string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every output sample, pop whatever the scoreboard expects now.
  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        act = actual(exp_q[i].kind);
        checks++;
        if (exp_q[i].cyc < cyc || act !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %h want %h", exp_q[i].name, exp_q[i].cyc,
                   act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic mapped(logic [31:0] a);
    return (a == A_CTL) || (a == A_LO) || (a == A_HI);
  endfunction

  task automatic bus_write(logic [31:0] a, logic [3:0] m, logic [31:0] d);
    valid = 1'b1; addr = a; wmask = m; wdata = d;
    expect_at(cyc, K_ISV, 64'(mapped(a)), "wr_is_valid");
    expect_at(cyc + 1, K_RDY, 64'(mapped(a)), "wr_ready");
    step(1);
    valid = 1'b0; wmask = '0;
  endtask

  task automatic bus_read(logic [31:0] a, logic [31:0] exp_d, string nm);
    valid = 1'b1; addr = a; wmask = '0;
    expect_at(cyc, K_ISV, 64'(mapped(a)), "rd_is_valid");
    expect_at(cyc, K_RD, 64'(exp_d), nm);
    expect_at(cyc + 1, K_RDY, 64'(mapped(a)), "rd_ready");
    step(1);
    valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int n, m, p, c, d, e;

  initial begin
    // Reset state
    expect_at(2, K_CNT, 64'd0, "rst_cnt");
    expect_at(2, K_TICK, 64'd0, "rst_tick");
    expect_at(2, K_RDY, 64'd0, "rst_ready");
    expect_at(2, K_ISV, 64'd0, "rst_is_valid");
    step(2);
    checks++;
    if (timer_counter !== 64'd0) begin
      errors++;
      $display("FAIL rst_cnt_direct: got %h want %h", timer_counter, 64'd0);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick_direct: got %b want %b", tick, 1'b0);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_direct: got %b want %b", ready, 1'b0);
    end
    checks++;
    if (is_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_is_valid_direct: got %b want %b", is_valid, 1'b0);
    end
    resetn = 1'b1;
    n = cyc;
    // div=4: ticks 4, 8, 12 cycles after release
    expect_at(n + 3,  K_CNT, 64'd0, "d4_cnt_pre");
    expect_at(n + 3,  K_TICK, 64'd0, "d4_tick_pre");
    expect_at(n + 4,  K_CNT, 64'd1, "d4_cnt1");
    expect_at(n + 4,  K_TICK, 64'd1, "d4_tick1");
    expect_at(n + 5,  K_CNT, 64'd1, "d4_cnt1_hold");
    expect_at(n + 5,  K_TICK, 64'd0, "d4_tick_width");
    expect_at(n + 8,  K_CNT, 64'd2, "d4_cnt2");
    expect_at(n + 8,  K_TICK, 64'd1, "d4_tick2");
    expect_at(n + 12, K_CNT, 64'd3, "d4_cnt3");
    expect_at(n + 12, K_TICK, 64'd1, "d4_tick3");
    expect_at(n + 13, K_TICK, 64'd0, "d4_tick3_width");
    step(14);

    // Clear, then div=0 and div=1 both tick every cycle
    n = cyc;
    div = 16'd0;
    expect_at(n + 1,  K_CNT, 64'd0, "clr_cnt");
    expect_at(n + 1,  K_TICK, 64'd0, "clr_tick");
    expect_at(n + 2,  K_RDY, 64'd0, "ready_width");
    expect_at(n + 2,  K_CNT, 64'd1, "d0_cnt1");
    expect_at(n + 2,  K_TICK, 64'd1, "d0_tick1");
    expect_at(n + 11, K_CNT, 64'd10, "d0_cnt10");
    expect_at(n + 15, K_TICK, 64'd1, "d1_tick");
    expect_at(n + 21, K_CNT, 64'd20, "d1_cnt20");
    bus_write(A_CTL, 4'b0001, 32'h3);
    step(10);
    div = 16'd1;
    step(10);

    // Full load to all-ones, wrap to zero with tick
    n = cyc;
    div = 16'd3;
    expect_at(n + 1, K_CNT, 64'd20, "lo_no_commit");
    expect_at(n + 1, K_TICK, 64'd0, "lo_tick");
    expect_at(n + 2, K_CNT, 64'hFFFF_FFFF_FFFF_FFFF, "commit_ones");
    expect_at(n + 2, K_TICK, 64'd0, "commit_tick");
    expect_at(n + 4, K_CNT, 64'hFFFF_FFFF_FFFF_FFFF, "ones_hold");
    expect_at(n + 5, K_CNT, 64'd0, "wrap_cnt");
    expect_at(n + 5, K_TICK, 64'd1, "wrap_tick");
    bus_write(A_LO, 4'hF, 32'hFFFF_FFFF);
    bus_write(A_HI, 4'hF, 32'hFFFF_FFFF);
    step(3);
    bus_read(A_HI, 32'hFFFF_FFFF, "rd_hi_ones");

    // Partial LOAD_LO byte write, then partial LOAD_HI commit
    m = cyc;
    expect_at(m + 1, K_CNT, 64'd0, "part_cnt0");
    expect_at(m + 2, K_CNT, 64'd1, "part_cnt1");
    expect_at(m + 2, K_TICK, 64'd1, "part_tick");
    expect_at(m + 3, K_CNT, 64'hFFFF_FF12_FFFF_ABFF, "part_commit");
    expect_at(m + 3, K_TICK, 64'd0, "part_commit_tick");
    bus_write(A_LO, 4'b0010, 32'h0000_AB00);
    bus_read(A_LO, 32'hFFFF_ABFF, "rd_lo_part");
    bus_write(A_HI, 4'b0001, 32'h0000_0012);
    bus_read(A_HI, 32'hFFFF_FF12, "rd_hi_part");

    // div=100: commit coincident with a due tick
    p = cyc;
    div = 16'd100;
    c = p + 2;
    expect_at(c,       K_CNT, 64'd4, "d100_load4");
    expect_at(c + 99,  K_CNT, 64'd4, "d100_pre5");
    expect_at(c + 100, K_CNT, 64'd5, "d100_cnt5");
    expect_at(c + 100, K_TICK, 64'd1, "d100_tick5");
    expect_at(c + 101, K_TICK, 64'd0, "d100_tick5_width");
    expect_at(c + 199, K_CNT, 64'd5, "pre_commit_cnt");
    expect_at(c + 200, K_CNT, 64'h20, "coinc_commit_cnt");
    expect_at(c + 200, K_TICK, 64'd0, "coinc_commit_tick");
    expect_at(c + 299, K_TICK, 64'd0, "post_commit_no_tick");
    expect_at(c + 300, K_CNT, 64'h21, "post_commit_cnt");
    expect_at(c + 300, K_TICK, 64'd1, "post_commit_tick");
    bus_write(A_LO, 4'hF, 32'd4);
    bus_write(A_HI, 4'hF, 32'd0);
    step(50);
    bus_write(A_LO, 4'hF, 32'h20);
    step(148);
    bus_write(A_HI, 4'hF, 32'd0);

    // Same with clear instead of commit
    d = c + 300;
    expect_at(d + 99,  K_CNT, 64'h21, "pre_clear_cnt");
    expect_at(d + 100, K_CNT, 64'd0, "coinc_clear_cnt");
    expect_at(d + 100, K_TICK, 64'd0, "coinc_clear_tick");
    expect_at(d + 199, K_TICK, 64'd0, "post_clear_no_tick");
    expect_at(d + 200, K_CNT, 64'd1, "post_clear_cnt");
    expect_at(d + 200, K_TICK, 64'd1, "post_clear_tick");
    step(199);
    bus_write(A_CTL, 4'b0001, 32'h3);
    bus_read(A_LO, 32'h20, "rd_lo_after_clear");
    step(99);

    // Disable for 50 cycles, re-enable with div=8
    e = cyc;
    expect_at(e + 1,  K_CNT, 64'd1, "dis_cnt");
    expect_at(e + 25, K_CNT, 64'd1, "dis_cnt_frozen");
    expect_at(e + 25, K_TICK, 64'd0, "dis_tick");
    expect_at(e + 50, K_CNT, 64'd1, "dis_cnt_end");
    expect_at(e + 58, K_CNT, 64'd1, "reen_pre");
    expect_at(e + 58, K_TICK, 64'd0, "reen_tick_pre");
    expect_at(e + 59, K_CNT, 64'd2, "reen_cnt");
    expect_at(e + 59, K_TICK, 64'd1, "reen_tick");
    expect_at(e + 60, K_TICK, 64'd0, "reen_tick_width");
    expect_at(e + 63, K_CNT, 64'd2, "bad_wr_no_effect");
    bus_write(A_CTL, 4'b0001, 32'h0);
    div = 16'd8;
    step(49);
    bus_write(A_CTL, 4'b0001, 32'h1);
    step(9);
    bus_read(A_BAD, 32'h0, "rd_unmapped");
    bus_read(A_CTL, 32'h1, "rd_ctrl");
    bus_write(A_BAD, 4'hF, 32'hFFFF_FFFF);
    step(5);

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s @cyc %0d: got unchecked want checked", exp_q[i].name, exp_q[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
